// File: rtl/fta_bus_pkg.sv
// FTA 128-bit bus command/response types and the shared-port arbiter state encoding.
package fta_bus_pkg;

    typedef struct packed {
        logic         cyc;
        logic         we;
        logic [15:0]  sel;
        logic [7:0]   tid;
        logic [31:0]  adr;
        logic [127:0] dat;
    } fta_cmd_request128_t;

    typedef struct packed {
        logic         ack;
        logic         err;
        logic         rty;
        logic [7:0]   tid;
        logic [127:0] dat;
    } fta_cmd_response128_t;

    typedef enum logic [1:0] {StIdle, StIssue, StDone} fta_arb_state_t;

    // Any of the three completion flags ends a transaction.
    function automatic logic resp_done(input fta_cmd_response128_t r);
        return r.ack | r.err | r.rty;
    endfunction

endpackage

// File: rtl/fta_rr_pick.sv
// Combinational round-robin picker: scans from last_i+1 upward, wrapping, and returns
// a one-hot grant plus a valid flag.
module fta_rr_pick #(
    parameter int unsigned NPORT = 4,
    parameter int unsigned IdxW  = $clog2(NPORT)
) (
    input  logic [NPORT-1:0] req_i,
    input  logic [IdxW-1:0]  last_i,
    output logic [NPORT-1:0] grant_o,
    output logic             valid_o
);

    always_comb begin
        grant_o = '0;
        valid_o = 1'b0;
        // First pass covers ports above last_i, second pass wraps to port 0.
        for (int i = 0; i < NPORT; i++) begin
            if (!valid_o && req_i[i] && (IdxW'(i) > last_i)) begin
                grant_o[i] = 1'b1;
                valid_o    = 1'b1;
            end
        end
        for (int i = 0; i < NPORT; i++) begin
            if (!valid_o && req_i[i]) begin
                grant_o[i] = 1'b1;
                valid_o    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/fta_arbiter128.sv
// Round-robin arbiter sharing one 128-bit FTA target port, one transaction outstanding.
// Define FTA_ARB_TIMEOUT_EN to build a watchdog that completes a silent target with err.
module fta_arbiter128
    import fta_bus_pkg::*;
#(
    parameter int unsigned NPORT   = 4,
    parameter int unsigned TIMEOUT = 1024
) (
    input  logic                 clk,
    input  logic                 rst,
    input  fta_cmd_request128_t  req_i  [NPORT],
    output fta_cmd_response128_t resp_o [NPORT],
    output fta_cmd_request128_t  req_o,
    input  fta_cmd_response128_t resp_i,
    output logic [NPORT-1:0]     grant_o,
    output logic                 busy_o
);

    localparam int unsigned IdxW = $clog2(NPORT);

    fta_arb_state_t       state_q, state_d;
    fta_cmd_request128_t  req_q, req_d;
    fta_cmd_response128_t resp_q [NPORT];
    fta_cmd_response128_t resp_d [NPORT];
    logic [NPORT-1:0]     grant_q, grant_d;
    logic [IdxW-1:0]      owner_q, owner_d, last_q, last_d, pick_idx;
    logic [NPORT-1:0]     pick_req, pick_grant;
    logic                 pick_valid, complete, finish;
    fta_cmd_response128_t fwd_resp;

    always_comb begin
        pick_req = '0;
        for (int k = 0; k < NPORT; k++) pick_req[k] = req_i[k].cyc;
    end

    fta_rr_pick #(
        .NPORT (NPORT),
        .IdxW  (IdxW)
    ) u_pick (
        .req_i   (pick_req),
        .last_i  (last_q),
        .grant_o (pick_grant),
        .valid_o (pick_valid)
    );

    always_comb begin
        pick_idx = '0;
        for (int i = 0; i < NPORT; i++) begin
            if (pick_grant[i]) pick_idx = IdxW'(i);
        end
    end

    assign complete = resp_done(resp_i);

`ifdef FTA_ARB_TIMEOUT_EN
    localparam int unsigned CntW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            expire;

    assign expire = (cnt_q == CntW'(TIMEOUT - 1));
    // Held at zero outside ISSUE, so every ISSUE entry starts counting from zero.
    assign cnt_d  = (state_q == StIssue) ? cnt_q + CntW'(1) : '0;

    always_ff @(posedge clk) begin
        if (!rst) cnt_q <= '0;
        else      cnt_q <= cnt_d;
    end

    // A genuine completion in the expiry cycle is forwarded unmodified.
    always_comb begin
        fwd_resp = resp_i;
        if (!complete) begin
            fwd_resp     = '0;
            fwd_resp.err = 1'b1;
        end
    end
    assign finish = complete | expire;
`else
    logic unused_timeout;
    assign unused_timeout = ^TIMEOUT;
    assign fwd_resp       = resp_i;
    assign finish         = complete;
`endif

    always_ff @(posedge clk) begin
        if (!rst) state_q <= StIdle;
        else      state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (pick_valid) state_d = StIssue;
            StIssue: if (finish) state_d = StDone;
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        busy_o  = (state_q == StIssue) || (state_q == StDone);
        req_o   = req_q;
        grant_o = grant_q;
        resp_o  = resp_q;
    end

    always_comb begin
        req_d   = req_q;
        grant_d = grant_q;
        owner_d = owner_q;
        last_d  = last_q;
        for (int k = 0; k < NPORT; k++) resp_d[k] = '0;
        unique case (state_q)
            StIdle: begin
                if (pick_valid) begin
                    req_d   = req_i[pick_idx];
                    grant_d = pick_grant;
                    owner_d = pick_idx;
                end
            end
            StIssue: begin
                if (finish) begin
                    req_d           = '0;
                    grant_d         = '0;
                    last_d          = owner_q;
                    resp_d[owner_q] = fwd_resp;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            req_q   <= '0;
            grant_q <= '0;
            owner_q <= '0;
            last_q  <= IdxW'(NPORT - 1);
            for (int k = 0; k < NPORT; k++) resp_q[k] <= '0;
        end else begin
            req_q   <= req_d;
            grant_q <= grant_d;
            owner_q <= owner_d;
            last_q  <= last_d;
            for (int k = 0; k < NPORT; k++) resp_q[k] <= resp_d[k];
        end
    end

endmodule

// File: tb/tb_fta_arbiter128.sv
// Bench for fta_arbiter128: scripted requesters and target, scoreboarded issues and responses.
module tb_fta_arbiter128;
    import fta_bus_pkg::*;

    localparam int NP = 4;

    typedef struct {
        int         port;
        logic [7:0] tid;
        logic [31:0] adr;
    } iss_t;

    typedef struct {
        int           port;
        logic [2:0]   flags;
        logic [7:0]   tid;
        logic [127:0] dat;
    } exp_t;

    logic                 clk = 1'b0;
    logic                 rst = 1'b0;
    fta_cmd_request128_t  req_i  [NP];
    fta_cmd_response128_t resp_o [NP];
    fta_cmd_request128_t  req_o;
    fta_cmd_response128_t resp_i;
    logic [NP-1:0]        grant_o;
    logic                 busy_o;

    iss_t       iss_q[$];
    exp_t       exp_q[$];
    int         iss_cyc[$];
    int         resp_cyc[$];
    int         tgt_kind_q[$];
    int         checks   = 0;
    int         errors   = 0;
    int         resp_cnt = 0;
    int         cyc_n    = 0;
    int         tgt_lat  = 1;
    int         done_cnt [NP] = '{default: 0};
    int         want_cnt [NP] = '{default: 0};
    logic [7:0] tid_w    [NP] = '{default: 8'h00};
    logic       stray = 1'b0;

    fta_arbiter128 #(
        .NPORT   (NP),
        .TIMEOUT (8)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .req_i   (req_i),
        .resp_o  (resp_o),
        .req_o   (req_o),
        .resp_i  (resp_i),
        .grant_o (grant_o),
        .busy_o  (busy_o)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc_n <= cyc_n + 1;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation still running at %0t, required completion", $time);
        $fatal(1, "watchdog expired");
    end

    function automatic logic [31:0] adr_of(input logic [7:0] tid);
        return {24'hA00000, tid};
    endfunction

    function automatic int q_last(input int q[$]);
        return (q.size() > 0) ? q[q.size()-1] : -1000;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, required %0d", name, act, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic push_iss(input int port, input logic [7:0] tid);
        iss_t s;
        s.port = port;
        s.tid  = tid;
        s.adr  = adr_of(tid);
        iss_q.push_back(s);
    endtask

    task automatic push_exp(input int port, input logic [7:0] tid, input logic [2:0] flags,
                            input logic [127:0] dat);
        exp_t e;
        e.port  = port;
        e.flags = flags;
        e.tid   = tid;
        e.dat   = dat;
        exp_q.push_back(e);
    endtask

    // Expected issue plus the target echoing tid and adr back.
    task automatic push_txn(input int port, input logic [7:0] tid, input logic [2:0] flags);
        push_iss(port, tid);
        push_exp(port, tid, flags, {4{adr_of(tid)}});
    endtask

    task automatic wait_resp(input int n, input int budget);
        int k = 0;
        while (resp_cnt < n && k < budget) begin
            @(negedge clk);
            #1;
            k++;
        end
        chk("wait_resp", int'(resp_cnt >= n), 1);
    endtask

    function automatic int any_resp();
        int r = 0;
        for (int j = 0; j < NP; j++) if (resp_o[j] != '0) r = 1;
        return r;
    endfunction

    // Requesters: hold cyc until enough ack/err completions have been seen (rty keeps it up).
    initial begin
        for (int p = 0; p < NP; p++) req_i[p] = '0;
        forever begin
            @(posedge clk);
            #2;
            for (int p = 0; p < NP; p++) begin
                req_i[p] = '0;
                if (done_cnt[p] < want_cnt[p]) begin
                    req_i[p].cyc = 1'b1;
                    req_i[p].sel = '1;
                    req_i[p].tid = tid_w[p];
                    req_i[p].adr = adr_of(tid_w[p]);
                    req_i[p].dat = {4{~adr_of(tid_w[p])}};
                end
            end
        end
    end

    // Target: answers tgt_lat cycles after first seeing req_o; kind 0 ack, 1 err, 2 rty, 3 silent.
    initial begin
        int seen = 0;
        int kind;
        resp_i = '0;
        forever begin
            @(posedge clk);
            #3;
            resp_i = '0;
            if (req_o.cyc) seen++;
            else           seen = 0;
            if (stray) begin
                resp_i.ack = 1'b1;
                resp_i.tid = 8'hEE;
            end else if (req_o.cyc && seen == tgt_lat + 1) begin
                kind = (tgt_kind_q.size() > 0) ? tgt_kind_q.pop_front() : 0;
                if (kind != 3) begin
                    resp_i.ack = (kind == 0);
                    resp_i.err = (kind == 1);
                    resp_i.rty = (kind == 2);
                    resp_i.tid = req_o.tid;
                    resp_i.dat = {4{req_o.adr}};
                end
            end
        end
    end

    // Monitor: pops the scoreboard on each new issue and each response pulse.
    initial begin
        iss_t       s;
        exp_t       e;
        logic       prev_cyc;
        logic [2:0] fl;
        prev_cyc = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                if (req_o.cyc && !prev_cyc) begin
                    checks++;
                    iss_cyc.push_back(cyc_n);
                    if (iss_q.size() == 0) begin
                        errors++;
                        $display("FAIL issue_unexpected: grant %b tid %h, required no issue",
                                 grant_o, req_o.tid);
                    end else begin
                        s = iss_q.pop_front();
                        if (int'(grant_o) != (1 << s.port) || req_o.tid != s.tid ||
                            req_o.adr != s.adr) begin
                            errors++;
                            $display("FAIL issue: grant %b tid %h adr %h, required port %0d tid %h adr %h",
                                     grant_o, req_o.tid, req_o.adr, s.port, s.tid, s.adr);
                        end
                    end
                end
                for (int j = 0; j < NP; j++) begin
                    if (resp_o[j] != '0) begin
                        checks++;
                        resp_cnt++;
                        resp_cyc.push_back(cyc_n);
                        fl = {resp_o[j].ack, resp_o[j].err, resp_o[j].rty};
                        if (exp_q.size() == 0) begin
                            errors++;
                            $display("FAIL resp_unexpected: port %0d flags %b tid %h, required none",
                                     j, fl, resp_o[j].tid);
                        end else begin
                            e = exp_q.pop_front();
                            if (j != e.port || fl != e.flags || resp_o[j].tid != e.tid ||
                                resp_o[j].dat != e.dat || grant_o != '0 || !busy_o) begin
                                errors++;
                                $display("FAIL resp: port %0d flags %b tid %h grant %b busy %b, required port %0d flags %b tid %h grant 0 busy 1",
                                         j, fl, resp_o[j].tid, grant_o, busy_o,
                                         e.port, e.flags, e.tid);
                            end
                        end
                        if (resp_o[j].ack || resp_o[j].err) done_cnt[j]++;
                    end
                end
            end
            prev_cyc = req_o.cyc;
        end
    end

    initial begin
        int t0;
        int base;
        int nb;

        // Reset values
        rst = 1'b0;
        step(3);
        @(negedge clk);
        chk("reset_req_o", int'(req_o != '0), 0);
        chk("reset_grant", int'(grant_o), 0);
        chk("reset_busy", int'(busy_o), 0);
        chk("reset_resp", any_resp(), 0);
        @(posedge clk);
        #1;
        rst = 1'b1;

        // Single requester on port 2, target answers 2 cycles after seeing req_o
        step(2);
        t0      = cyc_n;
        base    = resp_cnt;
        tgt_lat = 2;
        push_txn(2, 8'h02, 3'b100);
        tid_w[2]    = 8'h02;
        want_cnt[2] = done_cnt[2] + 1;
        wait_resp(base + 1, 20);
        chk("single_req_latency", q_last(iss_cyc) - t0, 1);
        chk("single_resp_latency", q_last(resp_cyc) - t0, 4);
        @(negedge clk);
        chk("single_grant_after", int'(grant_o), 0);
        chk("single_busy_after", int'(busy_o), 0);
        tgt_lat = 1;

        // Reset during ISSUE abandons the transaction
        step(1);
        tgt_kind_q.push_back(3);
        push_iss(1, 8'h11);
        tid_w[1]    = 8'h11;
        want_cnt[1] = done_cnt[1] + 1;
        step(4);
        chk("hang_busy", int'(busy_o), 1);
        rst         = 1'b0;
        want_cnt[1] = done_cnt[1];
        step(1);
        rst = 1'b1;
        @(negedge clk);
        chk("midrst_req_o", int'(req_o != '0), 0);
        chk("midrst_grant", int'(grant_o), 0);
        chk("midrst_busy", int'(busy_o), 0);

        // All ports continuously requesting: grants 0,1,2,3,0,1 every 4 cycles
        step(1);
        base = resp_cnt;
        nb   = iss_cyc.size();
        for (int r = 0; r < 6; r++) push_txn(r % NP, 8'(32'h20 + r % NP), 3'b100);
        for (int p = 0; p < NP; p++) begin
            tid_w[p]    = 8'(32'h20 + p);
            want_cnt[p] = 1000;
        end
        wait_resp(base + 6, 60);
        step(1);
        for (int p = 0; p < NP; p++) want_cnt[p] = done_cnt[p];
        chk("rr_issue_count", iss_cyc.size(), nb + 6);
        if (iss_cyc.size() >= nb + 6) begin
            for (int i = 1; i < 6; i++) chk("rr_spacing", iss_cyc[nb+i] - iss_cyc[nb+i-1], 4);
        end
        step(3);
        chk("rr_idle_after", int'(busy_o), 0);

        // rty to port 1 releases and rotates to port 2 while port 1 keeps cyc
        base = resp_cnt;
        push_txn(0, 8'h30, 3'b100);
        tid_w[0]    = 8'h30;
        want_cnt[0] = done_cnt[0] + 1;
        wait_resp(base + 1, 20);
        step(1);
        push_txn(1, 8'h31, 3'b001);
        push_txn(2, 8'h32, 3'b100);
        push_txn(1, 8'h31, 3'b100);
        tgt_kind_q.push_back(2);
        tid_w[1]    = 8'h31;
        tid_w[2]    = 8'h32;
        want_cnt[1] = done_cnt[1] + 1;
        want_cnt[2] = done_cnt[2] + 1;
        wait_resp(base + 4, 60);
        step(3);

        // Silent target on port 3
        base = resp_cnt;
        push_iss(3, 8'h43);
        tgt_kind_q.push_back(3);
        tid_w[3] = 8'h43;
`ifdef FTA_ARB_TIMEOUT_EN
        push_exp(3, 8'h00, 3'b010, '0);
        want_cnt[3] = done_cnt[3] + 1;
        wait_resp(base + 1, 40);
        chk("timeout_latency", q_last(resp_cyc) - q_last(iss_cyc), 8);
        step(1);
        stray = 1'b1;
        step(1);
        stray = 1'b0;
        step(3);
        chk("late_ack_busy", int'(busy_o), 0);
        chk("late_ack_not_fwd", resp_cnt, base + 1);
`else
        want_cnt[3] = done_cnt[3] + 1;
        step(20);
        chk("no_timeout_busy", int'(busy_o), 1);
        chk("no_timeout_grant", int'(grant_o), 8);
        chk("no_timeout_resp", resp_cnt, base);
        rst         = 1'b0;
        want_cnt[3] = done_cnt[3];
        step(1);
        rst = 1'b1;
        step(1);
        chk("no_timeout_released", int'(busy_o), 0);
`endif

        // Stray ack while idle with no requests
        step(2);
        base  = resp_cnt;
        stray = 1'b1;
        step(1);
        stray = 1'b0;
        step(2);
        @(negedge clk);
        chk("stray_busy", int'(busy_o), 0);
        chk("stray_grant", int'(grant_o), 0);
        chk("stray_no_resp", resp_cnt, base);

        chk("exp_queue_empty", exp_q.size(), 0);
        chk("iss_queue_empty", iss_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
